// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and types used by the PC path and the return-address stack.
package cpu_pkg;
   localparam int PC_W    = 12;
   localparam int DATA_W  = 8;
   localparam int INSTR_W = 19;

   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      PUSH_OVF,
      POP,
      POP_UNF,
      REPL,
      PASS
   } stack_op_t;

   typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/stack_mem.sv
// Return-stack storage: DEPTH x WIDTH register array, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module stack_mem #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 12,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/pc_return_stack.sv
// LIFO of CALL return addresses: per-cycle op decode, occupancy counter, registered pop
// result with a one-cycle valid pulse, and sticky overflow/underflow flags.
//
// Handshake: push/pop are single-cycle strobes with no backpressure; a pop that finds
// data (or a push+pop on an empty stack) yields pop_valid high for exactly the next cycle,
// with pop_data holding that value until the next successful pop.
module pc_return_stack
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = $bits(pc_t),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   output logic [WIDTH-1:0] top,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);
   localparam int              AW       = CNT_W - 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] pop_data_q, pop_data_d;
   logic             pop_valid_q, pop_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   stack_op_t        op;
   logic             empty_w, full_w;
   logic [AW-1:0]    top_idx;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_rdata;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CNT_FULL);
   // Low bits wrap to DEPTH-1 when full, which is exactly the top slot.
   assign top_idx = AW'(count_q[AW-1:0] - AW'(1));

   always_comb begin
      op = IDLE;
      unique case ({push, pop})
         2'b10:   op = full_w  ? PUSH_OVF : PUSH;
         2'b01:   op = empty_w ? POP_UNF  : POP;
         2'b11:   op = empty_w ? PASS     : REPL;
         default: op = IDLE;
      endcase
   end

   always_comb begin
      count_d     = count_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = top_idx;
      unique case (op)
         PUSH: begin
            mem_we    = 1'b1;
            mem_waddr = count_q[AW-1:0];
            count_d   = count_q + CNT_ONE;
         end
         POP: begin
            pop_data_d  = mem_rdata;
            pop_valid_d = 1'b1;
            count_d     = count_q - CNT_ONE;
         end
         REPL: begin
            pop_data_d  = mem_rdata;
            pop_valid_d = 1'b1;
            mem_we      = 1'b1;
         end
         PASS: begin
            pop_data_d  = push_data;
            pop_valid_d = 1'b1;
         end
         default: ;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_d  = (overflow_q  & ~clr_err) | (op == PUSH_OVF);
      underflow_d = (underflow_q & ~clr_err) | (op == POP_UNF);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   stack_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (push_data),
      .raddr (top_idx),
      .rdata (mem_rdata)
   );

   assign pop_data  = pop_data_q;
   assign pop_valid = pop_valid_q;
   assign top       = empty_w ? '0 : mem_rdata;
   assign count     = count_q;
   assign empty     = empty_w;
   assign full      = full_w;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack: scenario tasks with inline hand-computed checks.
module tb_pc_return_stack;
   localparam int DEPTH = 8;
   localparam int WIDTH = 12;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             push = 1'b0;
   logic [WIDTH-1:0] push_data = '0;
   logic             pop = 1'b0;
   logic             clr_err = 1'b0;
   logic [WIDTH-1:0] pop_data;
   logic             pop_valid;
   logic [WIDTH-1:0] top;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   int checks = 0;
   int failures = 0;

   pc_return_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .pop_valid (pop_valid),
      .top       (top),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      push = 1'b0;
      pop = 1'b0;
      clr_err = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic do_push(input logic [WIDTH-1:0] v);
      push = 1'b1;
      push_data = v;
      step();
      push = 1'b0;
   endtask

   task automatic do_pop();
      pop = 1'b1;
      step();
      pop = 1'b0;
   endtask

   task automatic do_repl(input logic [WIDTH-1:0] v);
      push = 1'b1;
      pop = 1'b1;
      push_data = v;
      step();
      push = 1'b0;
      pop = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b expected 0", full); end
      checks++; if (top !== 12'h000) begin failures++; $display("FAIL reset_top: got %h expected 000", top); end
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid: got %b expected 0", pop_valid); end
      checks++; if (pop_data !== 12'h000) begin failures++; $display("FAIL reset_pop_data: got %h expected 000", pop_data); end
      checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {overflow, underflow}); end
   endtask

   task automatic test_push_pop();
      do_push(12'h010);
      checks++; if (top !== 12'h010) begin failures++; $display("FAIL push1_top: got %h expected 010", top); end
      do_push(12'h020);
      do_push(12'h030);
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL push3_count: got %0d expected 3", count); end
      checks++; if (top !== 12'h030) begin failures++; $display("FAIL push3_top: got %h expected 030", top); end
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL push_no_valid: got %b expected 0", pop_valid); end
      do_pop();
      checks++; if (pop_data !== 12'h030) begin failures++; $display("FAIL pop_data: got %h expected 030", pop_data); end
      checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL pop_valid: got %b expected 1", pop_valid); end
      checks++; if (count !== 4'd2) begin failures++; $display("FAIL pop_count: got %0d expected 2", count); end
      checks++; if (top !== 12'h020) begin failures++; $display("FAIL pop_top: got %h expected 020", top); end
      step();
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL pop_valid_pulse: got %b expected 0", pop_valid); end
      checks++; if (pop_data !== 12'h030) begin failures++; $display("FAIL pop_data_hold: got %h expected 030", pop_data); end
   endtask

   task automatic test_replace();
      do_repl(12'h0AA);
      checks++; if (pop_data !== 12'h020) begin failures++; $display("FAIL repl_pop_data: got %h expected 020", pop_data); end
      checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL repl_pop_valid: got %b expected 1", pop_valid); end
      checks++; if (count !== 4'd2) begin failures++; $display("FAIL repl_count: got %0d expected 2", count); end
      checks++; if (top !== 12'h0AA) begin failures++; $display("FAIL repl_top: got %h expected 0AA", top); end
   endtask

   task automatic test_back_to_back();
      pop = 1'b1;
      step();
      checks++; if ({pop_valid, pop_data} !== {1'b1, 12'h0AA}) begin failures++; $display("FAIL b2b_pop1: got %b/%h expected 1/0AA", pop_valid, pop_data); end
      step();
      pop = 1'b0;
      checks++; if ({pop_valid, pop_data} !== {1'b1, 12'h010}) begin failures++; $display("FAIL b2b_pop2: got %b/%h expected 1/010", pop_valid, pop_data); end
      checks++; if ({empty, count} !== {1'b1, 4'd0}) begin failures++; $display("FAIL b2b_empty: got %b/%0d expected 1/0", empty, count); end
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL b2b_underflow: got %b expected 0", underflow); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         do_push(12'h100 + 12'(i));
      end
      checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full: got %b expected 1", full); end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count: got %0d expected 8", count); end
      checks++; if (top !== 12'h107) begin failures++; $display("FAIL fill_top: got %h expected 107", top); end
      do_push(12'h1FF);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count: got %0d expected 8", count); end
      checks++; if (top !== 12'h107) begin failures++; $display("FAIL ovf_top: got %h expected 107", top); end
      step();
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
      do_repl(12'h2AB);
      checks++; if ({pop_valid, pop_data} !== {1'b1, 12'h107}) begin failures++; $display("FAIL full_repl_pop: got %b/%h expected 1/107", pop_valid, pop_data); end
      checks++; if ({count, top, overflow} !== {4'd8, 12'h2AB, 1'b0}) begin failures++; $display("FAIL full_repl_state: got %0d/%h/%b expected 8/2AB/0", count, top, overflow); end
   endtask

   task automatic test_underflow();
      do_reset();
      do_push(12'h033);
      do_pop();
      checks++; if (pop_data !== 12'h033) begin failures++; $display("FAIL unf_setup_pop: got %h expected 033", pop_data); end
      do_pop();
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_flag: got %b expected 1", underflow); end
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL unf_pop_valid: got %b expected 0", pop_valid); end
      checks++; if (pop_data !== 12'h033) begin failures++; $display("FAIL unf_pop_data_held: got %h expected 033", pop_data); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL unf_count: got %0d expected 0", count); end
      clr_err = 1'b1;
      pop = 1'b1;
      step();
      clr_err = 1'b0;
      pop = 1'b0;
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_set_wins: got %b expected 1", underflow); end
   endtask

   task automatic test_passthrough();
      do_repl(12'h055);
      checks++; if (pop_data !== 12'h055) begin failures++; $display("FAIL pass_pop_data: got %h expected 055", pop_data); end
      checks++; if (pop_valid !== 1'b1) begin failures++; $display("FAIL pass_pop_valid: got %b expected 1", pop_valid); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL pass_count: got %0d expected 0", count); end
      checks++; if ({empty, top} !== {1'b1, 12'h000}) begin failures++; $display("FAIL pass_empty: got %b/%h expected 1/000", empty, top); end
   endtask

   task automatic test_reset_mid_op();
      for (int i = 1; i <= 5; i++) begin
         do_push(12'(i) * 12'h011);
      end
      checks++; if (count !== 4'd5) begin failures++; $display("FAIL mid_count5: got %0d expected 5", count); end
      pop = 1'b1;
      step();
      checks++; if ({pop_valid, pop_data, count} !== {1'b1, 12'h055, 4'd4}) begin failures++; $display("FAIL mid_pop: got %b/%h/%0d expected 1/055/4", pop_valid, pop_data, count); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if (pop_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_pop_valid: got %b expected 0", pop_valid); end
      checks++; if ({count, empty} !== {4'd0, 1'b1}) begin failures++; $display("FAIL mid_rst_count: got %0d/%b expected 0/1", count, empty); end
      checks++; if (top !== 12'h000) begin failures++; $display("FAIL mid_rst_top: got %h expected 000", top); end
      checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL mid_rst_flags: got %b expected 00", {overflow, underflow}); end
      checks++; if (pop_data !== 12'h000) begin failures++; $display("FAIL mid_rst_pop_data: got %h expected 000", pop_data); end
      pop = 1'b0;
      step();
      rst = 1'b0;
      step();
      checks++; if ({count, pop_valid} !== {4'd0, 1'b0}) begin failures++; $display("FAIL post_rst_state: got %0d/%b expected 0/0", count, pop_valid); end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_replace();
      test_back_to_back();
      test_overflow();
      test_underflow();
      test_passthrough();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
